pwm_cfg_arbiter: RTL and testbench
==================================

Name: pwm_cfg_arbiter

Overview:
- Owns the PWM configuration register bank: en_out[15:0], en_pwm[15:0] and duty cycle, as five 8-bit registers at addresses 0..4.
- Arbitrates write requests between two requesters using round-robin. Port A is the SPI decoded-write path; port B is the on-chip sequencer/test path.
- Writes land in shadow registers. Shadows are committed to the active outputs only at a PWM period boundary, so the PWM never sees a half-updated configuration.
- An immediate mode bypasses the commit step.

Parameters:
NUM_REGS, 5, number of implemented registers; address >= NUM_REGS is rejected.
ADDR_W, 7, request address width.
DATA_W, 8, register width.
IMMEDIATE, 0, 1 = accepted write updates shadow and active in the same cycle; commit logic unused.

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
a_valid  in  1  port A write request
a_addr  in  ADDR_W  port A register address
a_data  in  DATA_W  port A write data
a_ready  out  1  port A transfer accepted this cycle (combinational)
b_valid  in  1  port B write request
b_addr  in  ADDR_W  port B register address
b_data  in  DATA_W  port B write data
b_ready  out  1  port B transfer accepted this cycle (combinational)
period_end  in  1  single-cycle pulse at PWM period boundary
en_reg_out_7_0  out  8  active reg 0
en_reg_out_15_8  out  8  active reg 1
en_reg_pwm_7_0  out  8  active reg 2
en_reg_pwm_15_8  out  8  active reg 3
pwm_duty_cycle  out  8  active reg 4
cfg_pending  out  1  any shadow register dirty (uncommitted)
err_addr  out  1  one-cycle pulse: accepted write had address >= NUM_REGS

Behaviour:
Reset (rst high, async):
- State = IDLE; all active and shadow registers = 0; dirty[4:0] = 0; commit_req = 0.
- last_grant = B, so A wins the first tie.
- err_addr = 0; a_ready = b_ready = 0 while rst is high.
- Reset mid-transaction discards the captured write and any pending commit.

Handshake:
- A transfer occurs when valid && ready in the same cycle.
- Requesters must hold valid, addr and data stable until ready.
- ready is high only in IDLE, only for the winner, and only when no commit has priority.

FSM states: IDLE, WRITE, COMMIT.

IDLE:
- Commit priority: if (commit_req || period_end) && dirty != 0, go to COMMIT. No grant this cycle; commit_req clears.
- Otherwise, if any valid: pick a winner.
  - Only one valid: that port wins.
  - Both valid: the port not equal to last_grant wins.
  - Assert the winner's ready, capture addr/data, set last_grant = winner, go to WRITE.
- period_end with dirty == 0: ignored; commit_req stays 0.

WRITE (1 cycle):
- If addr < NUM_REGS: shadow[addr] <= data and dirty[addr] <= 1. If IMMEDIATE, active[addr] <= data as well and dirty is not set.
- Else: pulse err_addr for this cycle; no register changes.
- Return to IDLE.
- Throughput is one write per 2 cycles.
- Writing the same address twice before a commit: last value wins.

COMMIT (1 cycle):
- For each i with dirty[i]: active[i] <= shadow[i].
- dirty <= 0, then return to IDLE.
- Active outputs change on the clock edge leaving COMMIT, two edges after the period_end pulse when seen in IDLE.

period_end arriving in WRITE or COMMIT:
- In WRITE: set commit_req. It is serviced on the next IDLE cycle, and the data written in that WRITE is included.
- In COMMIT: ignored.
- Multiple period_end pulses before service collapse into one commit.

Other rules:
- cfg_pending = |dirty; always 0 when IMMEDIATE = 1.
- Data-width rule: only the low ADDR_W bits of addr are compared against NUM_REGS; no truncation aliasing (e.g. addr 0x45 is an error, not reg 5).

Test Plan:
- Single write: A writes addr 4 = 0x80, no period_end → a_ready one cycle, cfg_pending = 1, pwm_duty_cycle stays 0x00. Pulse period_end → pwm_duty_cycle = 0x80 two edges later, cfg_pending = 0.
- Contention: A and B both valid every cycle for 6 grants, starting from reset → grants alternate A, B, A, B, A, B. Never both ready in one cycle; ready never high in WRITE.
- Commit vs request: period_end pulses in IDLE with dirty != 0 while a_valid is high → no a_ready that cycle; COMMIT first, then A is granted the following IDLE cycle.
- Deferred commit: period_end during a WRITE of addr 0 = 0x0F → commit_req set; next cycle COMMIT; en_reg_out_7_0 = 0x0F.
- Bad address: B writes addr 5 and addr 0x7F → err_addr pulses once per write, no outputs change, cfg_pending unchanged.
- Async reset: assert rst mid-WRITE with dirty = 0b10101 → all outputs 0 immediately, cfg_pending = 0. After release, the first tie goes to A. With IMMEDIATE = 1, A writes addr 2 = 0x33 → en_reg_pwm_7_0 = 0x33 at the WRITE edge, without period_end.

Source files
------------

// File: rtl/pwm_cfg_arbiter.sv
// pwm_cfg_arbiter
// Round-robin write arbiter in front of the PWM configuration bank. Requesters
// write shadow registers; the shadows are copied to the active outputs only at
// a PWM period boundary so the PWM never sees a half-updated configuration.
// With IMMEDIATE set, accepted writes go straight to the active outputs.
// The five active outputs map to registers 0..4, so NUM_REGS must be >= 5.
module pwm_cfg_arbiter #(
    parameter int NUM_REGS  = 5,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8,
    parameter bit IMMEDIATE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              period_end,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              cfg_pending,
    output logic              err_addr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Only the full ADDR_W-bit address is compared, so e.g. 0x45 never aliases reg 5.
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS);

    state_t              state;
    state_t              state_nxt;
    logic                last_grant_b;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_data;
    logic [DATA_W-1:0]   shadow [NUM_REGS];
    logic [DATA_W-1:0]   active [NUM_REGS];
    logic [NUM_REGS-1:0] dirty;
    logic [NUM_REGS-1:0] wr_sel;
    logic                commit_req;
    logic                commit_pri;
    logic                grant_a;
    logic                grant_b;
    logic                addr_ok;

    assign addr_ok = (cap_addr < ADDR_LIMIT);

    // Next state and arbitration: a due commit beats any request; ties go to
    // the port that did not win last time.
    always_comb begin
        state_nxt  = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        commit_pri = (commit_req || period_end) && (dirty != '0);
        case (state)
            IDLE: begin
                if (commit_pri) begin
                    state_nxt = COMMIT;
                end else if (a_valid && (!b_valid || last_grant_b)) begin
                    grant_a   = 1'b1;
                    state_nxt = WRITE;
                end else if (b_valid) begin
                    grant_b   = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE:   state_nxt = IDLE;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-register write strobe for the captured address during WRITE.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = (state == WRITE) && addr_ok && (cap_addr == ADDR_W'(i));
        end
    end

    assign a_ready  = grant_a && !rst;
    assign b_ready  = grant_b && !rst;
    assign err_addr = (state == WRITE) && !addr_ok;

    // State register, round-robin history and captured request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_b <= 1'b1;
            cap_addr     <= '0;
            cap_data     <= '0;
        end else begin
            state <= state_nxt;
            if (grant_a) begin
                last_grant_b <= 1'b0;
                cap_addr     <= a_addr;
                cap_data     <= a_data;
            end else if (grant_b) begin
                last_grant_b <= 1'b1;
                cap_addr     <= b_addr;
                cap_data     <= b_data;
            end
        end
    end

    // A period boundary seen mid-write is remembered and serviced on the next
    // IDLE cycle; any IDLE cycle consumes it, pulses collapse into one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_req <= 1'b0;
        end else if ((state == WRITE) && period_end && !IMMEDIATE) begin
            commit_req <= 1'b1;
        end else if (state == IDLE) begin
            commit_req <= 1'b0;
        end
    end

    // Shadow/active bank: writes fill shadows and mark them dirty, COMMIT
    // copies every dirty shadow to its active register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            dirty <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    shadow[i] <= cap_data;
                    if (IMMEDIATE) begin
                        active[i] <= cap_data;
                    end else begin
                        dirty[i] <= 1'b1;
                    end
                end else if ((state == COMMIT) && dirty[i]) begin
                    active[i] <= shadow[i];
                    dirty[i]  <= 1'b0;
                end
            end
        end
    end

    assign en_reg_out_7_0  = active[0];
    assign en_reg_out_15_8 = active[1];
    assign en_reg_pwm_7_0  = active[2];
    assign en_reg_pwm_15_8 = active[3];
    assign pwm_duty_cycle  = active[4];
    assign cfg_pending     = |dirty;

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Testbench for pwm_cfg_arbiter: directed vector table, hand-written corner
// sequences (async reset mid-write, immediate mode) and a randomized run
// against a transaction-level reference model.
module tb_pwm_cfg_arbiter;

    logic       clk;
    logic       rst;
    logic       a_valid, b_valid, period_end;
    logic [6:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, cfg_pending, err_addr;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    logic       ia_valid;
    logic [6:0] ia_addr;
    logic [7:0] ia_data;
    logic       i_ar, i_br, i_pd, i_err;
    logic [7:0] i_o0, i_o1, i_p0, i_p1, i_dc;

    int n_vec = 0;
    int n_mis = 0;

    pwm_cfg_arbiter #(.NUM_REGS(5), .ADDR_W(7), .DATA_W(8), .IMMEDIATE(1'b0)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .period_end(period_end),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .cfg_pending(cfg_pending), .err_addr(err_addr)
    );

    pwm_cfg_arbiter #(.NUM_REGS(5), .ADDR_W(7), .DATA_W(8), .IMMEDIATE(1'b1)) dut_imm (
        .clk(clk), .rst(rst),
        .a_valid(ia_valid), .a_addr(ia_addr), .a_data(ia_data), .a_ready(i_ar),
        .b_valid(1'b0), .b_addr(7'h00), .b_data(8'h00), .b_ready(i_br),
        .period_end(1'b0),
        .en_reg_out_7_0(i_o0), .en_reg_out_15_8(i_o1),
        .en_reg_pwm_7_0(i_p0), .en_reg_pwm_15_8(i_p1),
        .pwm_duty_cycle(i_dc), .cfg_pending(i_pd), .err_addr(i_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       av; logic [6:0] aa; logic [7:0] ad;
        logic       bv; logic [6:0] ba; logic [7:0] bd;
        logic       pe;
        logic       ar; logic br; logic er;
        logic [7:0] o0; logic [7:0] o1; logic [7:0] dc;
        logic       pd;
    } vec_t;

    vec_t vecs[$];

    // ---------------- reference model ----------------
    typedef struct {
        bit         is_commit;
        logic [6:0] addr;
        logic [7:0] data;
    } op_t;

    logic [7:0] m_sh  [5];
    logic [7:0] m_act [5];
    bit         m_dirty [5];
    bit         m_last_b;
    bit         m_cmreq;
    op_t        m_ops[$];

    function automatic bit m_any();
        bit r = 1'b0;
        for (int i = 0; i < 5; i++) r = r | m_dirty[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_sh[i] = 8'h00; m_act[i] = 8'h00; m_dirty[i] = 1'b0;
        end
        m_last_b = 1'b1;
        m_cmreq  = 1'b0;
        m_ops.delete();
    endtask

    // One clock of the bank, evaluated on the inputs of this cycle. While an
    // operation is scheduled the bank is busy and grants nothing.
    task automatic model_cycle(output bit ear, output bit ebr, output bit eer);
        op_t op;
        int  ix;
        bit  pick_b;
        ear = 1'b0; ebr = 1'b0; eer = 1'b0;
        if (m_ops.size() == 0) begin
            if ((m_cmreq || period_end) && m_any()) begin
                op.is_commit = 1'b1; op.addr = 7'h00; op.data = 8'h00;
                m_ops.push_back(op);
            end else if (a_valid || b_valid) begin
                pick_b = b_valid && (!a_valid || !m_last_b);
                ear = !pick_b;
                ebr = pick_b;
                m_last_b = pick_b;
                op.is_commit = 1'b0;
                op.addr = pick_b ? b_addr : a_addr;
                op.data = pick_b ? b_data : a_data;
                m_ops.push_back(op);
            end
            m_cmreq = 1'b0;
        end else begin
            op = m_ops.pop_front();
            if (op.is_commit) begin
                for (int i = 0; i < 5; i++) begin
                    if (m_dirty[i]) m_act[i] = m_sh[i];
                    m_dirty[i] = 1'b0;
                end
            end else begin
                if (op.addr < 7'd5) begin
                    ix = int'(op.addr);
                    m_sh[ix] = op.data;
                    m_dirty[ix] = 1'b1;
                end else begin
                    eer = 1'b1;
                end
                if (period_end) m_cmreq = 1'b1;
            end
        end
    endtask

    function automatic logic [6:0] rnd_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) return 7'(r);
        else if (r == 7) return 7'h45;
        else return 7'h7F;
    endfunction

    task automatic wr_a(input logic [6:0] addr, input logic [7:0] data);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        a_valid = 1'b1; a_addr = addr; a_data = data;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (a_ready) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        n_vec++;
        if (!got) begin
            n_mis++;
            $display("FAIL wr_a_grant: a_ready never seen for addr %02h, required 1", addr);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic chk_main_zero(input string tag);
        chk({tag, ".out0"}, en_reg_out_7_0, 8'h00);
        chk({tag, ".out1"}, en_reg_out_15_8, 8'h00);
        chk({tag, ".pwm0"}, en_reg_pwm_7_0, 8'h00);
        chk({tag, ".pwm1"}, en_reg_pwm_15_8, 8'h00);
        chk({tag, ".duty"}, pwm_duty_cycle, 8'h00);
        chk({tag, ".pend"}, 8'(cfg_pending), 8'h00);
        chk({tag, ".a_ready"}, 8'(a_ready), 8'h00);
        chk({tag, ".err"}, 8'(err_addr), 8'h00);
    endtask

    initial begin
        bit ear, ebr, eer;
        bit a_hold, b_hold;

        // inputs: av aa ad bv ba bd pe | expected: ar br er o0 o1 dc pd
        // Contention from reset: A (reg0=A1) and B (reg1=B2) valid every cycle.
        vecs.push_back(vec_t'{1'b1,7'h00,8'hA1, 1'b1,7'h01,8'hB2, 1'b0, 1'b1,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b1,7'h00,8'hA1, 1'b1,7'h01,8'hB2, 1'b0, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b1,7'h00,8'hA1, 1'b1,7'h01,8'hB2, 1'b0, 1'b0,1'b1,1'b0, 8'h00,8'h00,8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b1,7'h00,8'hA1, 1'b1,7'h01,8'hB2, 1'b0, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b1,7'h00,8'hA1, 1'b1,7'h01,8'hB2, 1'b0, 1'b1,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b1,7'h00,8'hA1, 1'b1,7'h01,8'hB2, 1'b0, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b1,7'h00,8'hA1, 1'b1,7'h01,8'hB2, 1'b0, 1'b0,1'b1,1'b0, 8'h00,8'h00,8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b1,7'h00,8'hA1, 1'b1,7'h01,8'hB2, 1'b0, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b1,7'h00,8'hA1, 1'b1,7'h01,8'hB2, 1'b0, 1'b1,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b1,7'h00,8'hA1, 1'b1,7'h01,8'hB2, 1'b0, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b1,7'h00,8'hA1, 1'b1,7'h01,8'hB2, 1'b0, 1'b0,1'b1,1'b0, 8'h00,8'h00,8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b1,7'h00,8'hA1, 1'b1,7'h01,8'hB2, 1'b0, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b1});
        // Commit beats a pending A request; A granted after COMMIT.
        vecs.push_back(vec_t'{1'b1,7'h04,8'h80, 1'b0,7'h00,8'h00, 1'b1, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b1,7'h04,8'h80, 1'b0,7'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b1,7'h04,8'h80, 1'b0,7'h00,8'h00, 1'b0, 1'b1,1'b0,1'b0, 8'hA1,8'hB2,8'h00, 1'b0});
        // Single write of duty 0x80 pending until period_end, lands two edges later.
        vecs.push_back(vec_t'{1'b0,7'h00,8'h00, 1'b0,7'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0, 8'hA1,8'hB2,8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b0,7'h00,8'h00, 1'b0,7'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0, 8'hA1,8'hB2,8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b0,7'h00,8'h00, 1'b0,7'h00,8'h00, 1'b1, 1'b0,1'b0,1'b0, 8'hA1,8'hB2,8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b0,7'h00,8'h00, 1'b0,7'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0, 8'hA1,8'hB2,8'h00, 1'b1});
        // Deferred commit: period_end during the WRITE of reg0 = 0x0F.
        vecs.push_back(vec_t'{1'b1,7'h00,8'h0F, 1'b0,7'h00,8'h00, 1'b0, 1'b1,1'b0,1'b0, 8'hA1,8'hB2,8'h80, 1'b0});
        vecs.push_back(vec_t'{1'b0,7'h00,8'h00, 1'b0,7'h00,8'h00, 1'b1, 1'b0,1'b0,1'b0, 8'hA1,8'hB2,8'h80, 1'b0});
        vecs.push_back(vec_t'{1'b0,7'h00,8'h00, 1'b0,7'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0, 8'hA1,8'hB2,8'h80, 1'b1});
        vecs.push_back(vec_t'{1'b0,7'h00,8'h00, 1'b0,7'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0, 8'hA1,8'hB2,8'h80, 1'b1});
        // Bad addresses from B: 5 and 0x7F.
        vecs.push_back(vec_t'{1'b0,7'h00,8'h00, 1'b1,7'h05,8'h55, 1'b0, 1'b0,1'b1,1'b0, 8'h0F,8'hB2,8'h80, 1'b0});
        vecs.push_back(vec_t'{1'b0,7'h00,8'h00, 1'b0,7'h00,8'h00, 1'b0, 1'b0,1'b0,1'b1, 8'h0F,8'hB2,8'h80, 1'b0});
        vecs.push_back(vec_t'{1'b0,7'h00,8'h00, 1'b1,7'h7F,8'h66, 1'b0, 1'b0,1'b1,1'b0, 8'h0F,8'hB2,8'h80, 1'b0});
        vecs.push_back(vec_t'{1'b0,7'h00,8'h00, 1'b0,7'h00,8'h00, 1'b0, 1'b0,1'b0,1'b1, 8'h0F,8'hB2,8'h80, 1'b0});
        vecs.push_back(vec_t'{1'b0,7'h00,8'h00, 1'b0,7'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0, 8'h0F,8'hB2,8'h80, 1'b0});

        // Reset state, with a request pending to show ready is held low.
        rst = 1'b1;
        a_valid = 1'b1; a_addr = 7'h00; a_data = 8'h5A;
        b_valid = 1'b0; b_addr = 7'h00; b_data = 8'h00;
        period_end = 1'b0;
        ia_valid = 1'b0; ia_addr = 7'h00; ia_data = 8'h00;
        #12;
        chk_main_zero("reset");
        a_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
            period_end = vecs[i].pe;
            @(negedge clk);
            chk($sformatf("v%0d.a_ready", i), 8'(a_ready), 8'(vecs[i].ar));
            chk($sformatf("v%0d.b_ready", i), 8'(b_ready), 8'(vecs[i].br));
            chk($sformatf("v%0d.err_addr", i), 8'(err_addr), 8'(vecs[i].er));
            chk($sformatf("v%0d.out_7_0", i), en_reg_out_7_0, vecs[i].o0);
            chk($sformatf("v%0d.out_15_8", i), en_reg_out_15_8, vecs[i].o1);
            chk($sformatf("v%0d.duty", i), pwm_duty_cycle, vecs[i].dc);
            chk($sformatf("v%0d.pending", i), 8'(cfg_pending), 8'(vecs[i].pd));
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; period_end = 1'b0;

        // Immediate mode: write lands on the edge leaving WRITE, no period_end.
        @(posedge clk); #1;
        ia_valid = 1'b1; ia_addr = 7'h02; ia_data = 8'h33;
        @(negedge clk);
        chk("imm.a_ready", 8'(i_ar), 8'h01);
        @(posedge clk); #1;
        ia_valid = 1'b0;
        chk("imm.pwm0_in_write", i_p0, 8'h00);
        @(posedge clk); #1;
        chk("imm.pwm0_after", i_p0, 8'h33);
        chk("imm.pending", 8'(i_pd), 8'h00);

        // Async reset in the middle of a WRITE with dirty = 10101.
        wr_a(7'h00, 8'h01);
        wr_a(7'h02, 8'h02);
        wr_a(7'h04, 8'h04);
        wr_a(7'h01, 8'h07);
        chk("pre_rst.pending", 8'(cfg_pending), 8'h01);
        chk("pre_rst.duty", pwm_duty_cycle, 8'h80);
        #2;
        a_valid = 1'b1; a_addr = 7'h03; a_data = 8'hEE;
        rst = 1'b1;
        #1;
        chk_main_zero("rst_async");
        @(posedge clk); #1;
        chk_main_zero("rst_held");
        a_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // Last grant before reset was A; after reset the tie must still go to A.
        @(posedge clk); #1;
        a_valid = 1'b1; a_addr = 7'h03; a_data = 8'h11;
        b_valid = 1'b1; b_addr = 7'h03; b_data = 8'h22;
        @(negedge clk);
        chk("post_rst_tie.a_ready", 8'(a_ready), 8'h01);
        chk("post_rst_tie.b_ready", 8'(b_ready), 8'h00);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Randomized run against the reference model.
        model_reset();
        a_hold = 1'b0; b_hold = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            chk("rnd.out_7_0", en_reg_out_7_0, m_act[0]);
            chk("rnd.out_15_8", en_reg_out_15_8, m_act[1]);
            chk("rnd.pwm_7_0", en_reg_pwm_7_0, m_act[2]);
            chk("rnd.pwm_15_8", en_reg_pwm_15_8, m_act[3]);
            chk("rnd.duty", pwm_duty_cycle, m_act[4]);
            chk("rnd.pending", 8'(cfg_pending), 8'(m_any()));
            if (!a_hold) begin
                a_valid = ($urandom_range(0, 2) == 0);
                a_addr  = rnd_addr();
                a_data  = 8'($urandom);
            end
            if (!b_hold) begin
                b_valid = ($urandom_range(0, 2) == 0);
                b_addr  = rnd_addr();
                b_data  = 8'($urandom);
            end
            period_end = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            model_cycle(ear, ebr, eer);
            chk("rnd.a_ready", 8'(a_ready), 8'(ear));
            chk("rnd.b_ready", 8'(b_ready), 8'(ebr));
            chk("rnd.err_addr", 8'(err_addr), 8'(eer));
            a_hold = a_valid && !ear;
            b_hold = b_valid && !ebr;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
